// File: rtl/bus_arb_pkg.sv
// Shared defaults and helpers for the round-robin memory-bus arbiter.
package bus_arb_pkg;

  localparam int DEF_NUM_REQ    = 2;
  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_MAX_OUT    = 4;

  // Width needed to index n items, never less than one bit.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bus_arb_fifo.sv
// Synchronous FIFO holding the requester ID of every accepted-but-unanswered request.
module bus_arb_fifo
  import bus_arb_pkg::*;
#(
  parameter int Depth = DEF_MAX_OUT,
  parameter int Width = 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [Width-1:0]             din_i,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [Width-1:0]             head_o,
  output logic [$clog2(Depth+1)-1:0]   count_o
);

  localparam int PtrW = id_width(Depth);
  localparam int CntW = $clog2(Depth + 1);

  logic [Width-1:0] r_mem [Depth];
  logic [PtrW-1:0]  r_wr_ptr;
  logic [PtrW-1:0]  r_rd_ptr;
  logic [CntW-1:0]  r_count;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (r_count == CntW'(Depth));
  assign empty_o = (r_count == '0);
  assign head_o  = r_mem[r_rd_ptr];
  assign count_o = r_count;
  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && !empty_o;

  // NOTE: storage has no reset; an entry is only read after it was written, so resetting the pointers and count is enough.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= din_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// N-to-1 round-robin arbiter for the ready/valid memory bus with request lock
// and in-order response routing through an outstanding-ID FIFO.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int NumReq         = DEF_NUM_REQ,
  parameter int AddrWidth      = DEF_ADDR_WIDTH,
  parameter int DataWidth      = DEF_DATA_WIDTH,
  parameter int MaxOutstanding = DEF_MAX_OUT
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NumReq-1:0]               s_valid_i,
  output logic [NumReq-1:0]               s_ready_o,
  input  logic [NumReq*AddrWidth-1:0]     s_addr_i,
  input  logic [NumReq*DataWidth-1:0]     s_wdata_i,
  input  logic [NumReq*DataWidth/8-1:0]   s_wmask_i,
  output logic [DataWidth-1:0]            s_rdata_o,
  output logic [NumReq-1:0]               s_rvalid_o,
  output logic                            m_valid_o,
  input  logic                            m_ready_i,
  output logic [AddrWidth-1:0]            m_addr_o,
  output logic [DataWidth-1:0]            m_wdata_o,
  output logic [DataWidth/8-1:0]          m_wmask_o,
  input  logic [DataWidth-1:0]            m_rdata_i,
  input  logic                            m_rvalid_i,
  output logic                            err_o
);

  localparam int IdW   = id_width(NumReq);
  localparam int MaskW = DataWidth / 8;
  localparam int CntW  = $clog2(MaxOutstanding + 1);

  logic [IdW-1:0]  r_rr;
  logic [IdW-1:0]  r_lock_idx;
  logic            r_lock;
  logic            r_err;
  logic [IdW-1:0]  w_grant;
  logic [IdW-1:0]  w_head;
  logic            w_any_valid;
  logic            w_full;
  logic            w_empty;
  logic            w_hs;
  logic            w_pop;
  logic [CntW-1:0] w_count;

  // Lowest offset from the rr pointer wins, so scan from the far end and let later hits overwrite.
  // NOTE: every signal written here gets a default first so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    logic [IdW:0] sum;
    w_grant     = r_rr;
    w_any_valid = 1'b0;
    sum         = '0;
    if (r_lock) begin
      w_grant     = r_lock_idx;
      w_any_valid = s_valid_i[r_lock_idx];
    end else begin
      for (int k = NumReq - 1; k >= 0; k--) begin
        sum = {1'b0, r_rr} + (IdW+1)'(k);
        if (sum >= (IdW+1)'(NumReq)) sum = sum - (IdW+1)'(NumReq);
        if (s_valid_i[sum[IdW-1:0]]) begin
          w_grant     = sum[IdW-1:0];
          w_any_valid = 1'b1;
        end
      end
    end
  end

  assign m_addr_o  = s_addr_i[int'(w_grant)*AddrWidth +: AddrWidth];
  assign m_wdata_o = s_wdata_i[int'(w_grant)*DataWidth +: DataWidth];
  assign m_wmask_o = s_wmask_i[int'(w_grant)*MaskW +: MaskW];
  assign m_valid_o = !rst_i && w_any_valid && !w_full;
  assign w_hs      = m_valid_o && m_ready_i;
  assign w_pop     = m_rvalid_i && !w_empty;
  assign s_rdata_o = m_rdata_i;
  assign err_o     = r_err;

  always_comb begin
    s_ready_o  = '0;
    s_rvalid_o = '0;
    if (!rst_i && w_any_valid && m_ready_i && !w_full) s_ready_o[w_grant] = 1'b1;
    if (!rst_i && w_pop) s_rvalid_o[w_head] = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rr       <= '0;
      r_lock     <= 1'b0;
      r_lock_idx <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_hs) begin
        r_rr   <= (w_grant == IdW'(NumReq - 1)) ? '0 : w_grant + 1'b1;
        r_lock <= 1'b0;
      end else if (m_valid_o) begin
        r_lock     <= 1'b1;
        r_lock_idx <= w_grant;
      end
      // A response with nothing outstanding is a protocol error that sticks until reset.
      if (m_rvalid_i && (w_count == '0)) r_err <= 1'b1;
    end
  end

  bus_arb_fifo #(
    .Depth (MaxOutstanding),
    .Width (IdW)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_hs),
    .pop_i   (w_pop),
    .din_i   (w_grant),
    .full_o  (w_full),
    .empty_o (w_empty),
    .head_o  (w_head),
    .count_o (w_count)
  );

endmodule
